// File: rtl/host_packet_sequencer.sv
// Host transmit sequencer: frames one accepted command (optionally keystream-encrypted)
// as SOF, CMD_HI, CMD_LO, LEN, PAYLOAD..., CSUM, CLOSE on a valid/ready byte stream.
module host_packet_sequencer #(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] KEY_SEED      = 8'hA5,
    parameter logic [7:0] SOF_BYTE      = 8'hAA,
    parameter logic [7:0] CLOSE_BYTE    = 8'h7E
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [15:0]                cmd,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic [7:0]                 payload_len,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       enc_enabled,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_CMD_HI, S_CMD_LO, S_LEN, S_PAYLOAD, S_CSUM, S_CLOSE
    } state_t;

    localparam logic [15:0] CMD_ENC_ON  = 16'h0001;
    localparam logic [15:0] CMD_ENC_OFF = 16'h0002;
    localparam logic [15:0] CMD_DATA    = 16'h0003;
    localparam logic [7:0]  MAX_LEN     = 8'(PAYLOAD_BYTES);

    state_t                     state, state_next;
    logic [15:0]                cmd_r;
    logic [7:0]                 len_r;
    logic [7:0]                 remaining;
    logic [8*PAYLOAD_BYTES-1:0] payload_r;
    logic [7:0]                 lfsr;
    logic [7:0]                 csum;
    logic [7:0]                 tx_payload;
    logic                       accept;
    logic                       cmd_ok;
    logic                       byte_taken;

    assign accept     = cmd_valid && cmd_ready;
    assign byte_taken = out_valid && out_ready;
    // Payload register shifts right on every sent byte, so the current byte is always [7:0].
    assign tx_payload = enc_enabled ? (payload_r[7:0] ^ lfsr) : payload_r[7:0];

    always_comb begin
        unique case (cmd)
            CMD_ENC_ON, CMD_ENC_OFF: cmd_ok = 1'b1;
            CMD_DATA:                cmd_ok = (payload_len <= MAX_LEN);
            default:                 cmd_ok = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (which would infer a latch).
        state_next = state;
        unique case (state)
            S_IDLE:    if (accept && cmd_ok) state_next = S_SOF;
            S_SOF:     if (byte_taken) state_next = S_CMD_HI;
            S_CMD_HI:  if (byte_taken) state_next = S_CMD_LO;
            S_CMD_LO:  if (byte_taken) state_next = S_LEN;
            S_LEN:     if (byte_taken) state_next = (len_r == 8'd0) ? S_CSUM : S_PAYLOAD;
            S_PAYLOAD: if (byte_taken && remaining == 8'd1) state_next = S_CSUM;
            S_CSUM:    if (byte_taken) state_next = S_CLOSE;
            S_CLOSE:   if (byte_taken) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state != S_IDLE);
        unique case (state)
            S_SOF:     out_data = SOF_BYTE;
            S_CMD_HI:  out_data = cmd_r[15:8];
            S_CMD_LO:  out_data = cmd_r[7:0];
            S_LEN:     out_data = len_r;
            S_PAYLOAD: out_data = tx_payload;
            S_CSUM:    out_data = csum;
            S_CLOSE:   out_data = CLOSE_BYTE;
            default:   out_data = 8'h00;
        endcase
    end

    // NOTE: datapath registers are reset too, so a frame abandoned by reset leaves no stale key or checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_r       <= '0;
            len_r       <= '0;
            remaining   <= '0;
            payload_r   <= '0;
            lfsr        <= KEY_SEED;
            csum        <= '0;
            enc_enabled <= 1'b0;
            error       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            error      <= accept && !cmd_ok;
            frame_done <= (state == S_CLOSE) && byte_taken;
            if (accept && cmd_ok) begin
                cmd_r     <= cmd;
                payload_r <= payload;
                len_r     <= (cmd == CMD_DATA) ? payload_len : 8'd0;
                remaining <= (cmd == CMD_DATA) ? payload_len : 8'd0;
                csum      <= '0;
                lfsr      <= KEY_SEED;
                if (cmd == CMD_ENC_ON)  enc_enabled <= 1'b1;
                if (cmd == CMD_ENC_OFF) enc_enabled <= 1'b0;
            end else if (byte_taken) begin
                unique case (state)
                    S_CMD_HI, S_CMD_LO, S_LEN: csum <= csum ^ out_data;
                    S_PAYLOAD: begin
                        csum      <= csum ^ tx_payload;
                        payload_r <= payload_r >> 8;
                        remaining <= remaining - 8'd1;
                        lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
